// File: rtl/axi_mm_burst_sink_if.sv
// axi_mm_burst_sink_if: AXI4 write-channel bundle (AW, W, B) between a burst
// master and axi_mm_burst_sink.
//   master modport: drives AW/W payload and valids plus bready; sees readies,
//                   bresp and bvalid.
//   slave modport : the mirror image.
interface axi_mm_burst_sink_if #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [2:0]                  s_axi_awprot;
  logic [7:0]                  s_axi_awlen;
  logic [2:0]                  s_axi_awsize;
  logic [1:0]                  s_axi_awburst;
  logic                        s_axi_awvalid;
  logic                        s_axi_awready;
  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                        s_axi_wlast;
  logic                        s_axi_wvalid;
  logic                        s_axi_wready;
  logic [1:0]                  s_axi_bresp;
  logic                        s_axi_bvalid;
  logic                        s_axi_bready;

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awlen, s_axi_awsize, s_axi_awburst,
    output s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    output s_axi_bready
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awlen, s_axi_awsize, s_axi_awburst,
    input  s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready
  );
endinterface

// File: rtl/axi_mm_burst_sink.sv
// axi_mm_burst_sink: AXI4 write-only slave terminating one INCR burst at a
// time into a word-addressed RAM, with B response and traffic counters.
//   ACLK, ARESET : clock, asynchronous active-high reset
//   s_axi        : AW/W/B channels (slave modport)
//   wr_stall     : forces wready low while high
//   rd_idx       : read-back word index; rd_data returns RAM[rd_idx] 1 cycle later
//   burst_cnt    : completed bursts (saturating)
//   beat_cnt     : accepted W beats (saturating)
//   err_cnt      : bursts answered with a non-OKAY response (saturating)
module axi_mm_burst_sink #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH      = 1024,
  parameter int unsigned C_AXI_SIZE     = $clog2(AXI_DATA_WIDTH/8),
  parameter int unsigned IDX_WIDTH      = $clog2(MEM_DEPTH)
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  axi_mm_burst_sink_if.slave        s_axi,
  input  logic                      wr_stall,
  input  logic [IDX_WIDTH-1:0]      rd_idx,
  output logic [AXI_DATA_WIDTH-1:0] rd_data,
  output logic [15:0]               burst_cnt,
  output logic [15:0]               beat_cnt,
  output logic [15:0]               err_cnt
);

  localparam int unsigned NB = AXI_DATA_WIDTH / 8;
  // Wide enough that word index + len + 1 never overflows.
  localparam int unsigned CW = AXI_ADDR_WIDTH + 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                    state_q;
  logic                      awready_q;
  logic                      bvalid_q;
  logic [1:0]                bresp_q;
  logic [1:0]                cls_q;
  logic                      wr_ok_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_q;
  logic [IDX_WIDTH-1:0]      idx_q;
  logic [15:0]               burst_cnt_q;
  logic [15:0]               beat_cnt_q;
  logic [15:0]               err_cnt_q;
  logic [AXI_DATA_WIDTH-1:0] rd_data_q;
  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [CW-1:0] end_word_c;
  logic [1:0]    aw_cls_c;
  logic          w_hs_c;
  logic          last_beat_c;
  logic [1:0]    cls_upd_c;
  logic          unused_awprot;

  assign unused_awprot = ^s_axi.s_axi_awprot;

  // Error class of the incoming AW request, DECERR taking priority.
  always_comb begin
    end_word_c = CW'(s_axi.s_axi_awaddr >> C_AXI_SIZE) + CW'(s_axi.s_axi_awlen) + CW'(1);
    aw_cls_c   = RESP_OKAY;
    if (end_word_c > CW'(MEM_DEPTH)) begin
      aw_cls_c = RESP_DECERR;
    end else if (s_axi.s_axi_awburst != 2'b01 || s_axi.s_axi_awsize != 3'(C_AXI_SIZE)) begin
      aw_cls_c = RESP_SLVERR;
    end
  end

  assign s_axi.s_axi_wready = (state_q == ST_DATA) && !wr_stall;
  assign w_hs_c             = s_axi.s_axi_wready && s_axi.s_axi_wvalid;
  assign last_beat_c        = (beat_q == len_q);

  // A misplaced (or missing) wlast only downgrades an otherwise clean burst.
  always_comb begin
    cls_upd_c = cls_q;
    if (w_hs_c && (s_axi.s_axi_wlast != last_beat_c) && cls_q == RESP_OKAY) begin
      cls_upd_c = RESP_SLVERR;
    end
  end

  // Burst FSM with registered AW/B handshake outputs and counters.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      awready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      cls_q       <= RESP_OKAY;
      wr_ok_q     <= 1'b0;
      len_q       <= 8'd0;
      beat_q      <= 8'd0;
      idx_q       <= '0;
      burst_cnt_q <= 16'd0;
      beat_cnt_q  <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (awready_q && s_axi.s_axi_awvalid) begin
            awready_q <= 1'b0;
            len_q     <= s_axi.s_axi_awlen;
            beat_q    <= 8'd0;
            idx_q     <= IDX_WIDTH'(s_axi.s_axi_awaddr >> C_AXI_SIZE);
            cls_q     <= aw_cls_c;
            wr_ok_q   <= (aw_cls_c == RESP_OKAY);
            state_q   <= ST_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_hs_c) begin
            if (beat_cnt_q != 16'hFFFF) beat_cnt_q <= beat_cnt_q + 16'd1;
            idx_q  <= idx_q + IDX_WIDTH'(1);
            beat_q <= beat_q + 8'd1;
            cls_q  <= cls_upd_c;
            if (last_beat_c) begin
              bvalid_q <= 1'b1;
              bresp_q  <= cls_upd_c;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (s_axi.s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= ST_IDLE;
            if (burst_cnt_q != 16'hFFFF) burst_cnt_q <= burst_cnt_q + 16'd1;
            if (bresp_q != RESP_OKAY && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Storage write with per-byte enables; kept reset-free so it maps to RAM.
  always_ff @(posedge ACLK) begin
    if (w_hs_c && wr_ok_q) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (s_axi.s_axi_wstrb[b]) mem[idx_q][b*8 +: 8] <= s_axi.s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Registered read-back; a same-cycle write to rd_idx returns the old word.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rd_data_q <= '0;
    else        rd_data_q <= mem[rd_idx];
  end

  assign s_axi.s_axi_awready = awready_q;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bresp   = bresp_q;
  assign rd_data             = rd_data_q;
  assign burst_cnt           = burst_cnt_q;
  assign beat_cnt            = beat_cnt_q;
  assign err_cnt             = err_cnt_q;

endmodule

// File: tb/tb_axi_mm_burst_sink.sv
// Testbench for axi_mm_burst_sink: directed and randomized bursts against a
// transaction-level model; B responses are scoreboarded by a monitor process.
module tb_axi_mm_burst_sink;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int IW    = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_mm_burst_sink_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) intf ();

  logic          wr_stall;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_data;
  logic [15:0]   burst_cnt, beat_cnt, err_cnt;

  axi_mm_burst_sink #(
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)
  ) dut (
    .ACLK(clk), .ARESET(rst), .s_axi(intf.slave), .wr_stall(wr_stall),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .burst_cnt(burst_cnt), .beat_cnt(beat_cnt), .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_q[$];
  logic [31:0] mem_m [DEPTH];
  bit          mem_v [DEPTH];
  int          m_burst = 0, m_beat = 0, m_err = 0;
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_burst_cnt"}, 32'(burst_cnt), 32'(m_burst));
    chk({tag, "_beat_cnt"},  32'(beat_cnt),  32'(m_beat));
    chk({tag, "_err_cnt"},   32'(err_cnt),   32'(m_err));
  endtask

  // B-channel monitor: pops the scoreboard on every handshake and checks hold.
  logic       hold = 1'b0;
  logic [1:0] hold_resp = 2'b00;
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("b_hold_valid", 32'(intf.s_axi_bvalid), 32'd1);
        chk("b_hold_resp",  32'(intf.s_axi_bresp),  32'(hold_resp));
      end
      if (intf.s_axi_bvalid && intf.s_axi_bready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected actual=bresp %b required=no response", intf.s_axi_bresp);
        end else begin
          chk("bresp", 32'(intf.s_axi_bresp), 32'(exp_q.pop_front()));
        end
      end
      hold      = intf.s_axi_bvalid && !intf.s_axi_bready;
      hold_resp = intf.s_axi_bresp;
    end
  end

  task automatic rd_chk(input int idx);
    if (!mem_v[idx]) return;
    @(negedge clk);
    rd_idx = IW'(idx);
    @(negedge clk);
    #1;
    chk($sformatf("rd_data[%0d]", idx), rd_data, mem_m[idx]);
  endtask

  // One burst: AW, len+1 W beats (data from wd/ws), B. abort_at>=0 resets
  // the DUT right after that beat's handshake.
  task automatic do_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input int wlb, input int stall,
                          input int bdelay, input int abort_at);
    longint wend;
    logic [1:0] cls;
    bit ok;
    bit hs;
    int n;
    int word;
    wend = longint'(addr >> 2) + longint'(len) + 1;
    if (wend > DEPTH) cls = 2'b11;
    else if (burst != 2'b01 || size != 3'd2) cls = 2'b10;
    else cls = 2'b00;
    ok = (cls == 2'b00);
    for (int i = 0; i <= len; i++) begin
      if (((wlb < 0) ? (i == len) : (i == wlb)) != (i == len) && cls == 2'b00) cls = 2'b10;
    end

    @(negedge clk);
    n = 0;
    while (!intf.s_axi_awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!intf.s_axi_awready) begin
      chk("aw_ready_timeout", 32'(intf.s_axi_awready), 32'd1);
      return;
    end
    intf.s_axi_awaddr  = addr;
    intf.s_axi_awlen   = 8'(len);
    intf.s_axi_awsize  = size;
    intf.s_axi_awburst = burst;
    intf.s_axi_awprot  = 3'($urandom_range(0, 7));
    intf.s_axi_awvalid = 1'b1;
    if (abort_at < 0) exp_q.push_back(cls);
    @(negedge clk);
    intf.s_axi_awvalid = 1'b0;

    for (int i = 0; i <= len; i++) begin
      intf.s_axi_wvalid = 1'b1;
      intf.s_axi_wdata  = wd[i];
      intf.s_axi_wstrb  = ws[i];
      intf.s_axi_wlast  = (wlb < 0) ? (i == len) : (i == wlb);
      n  = 0;
      hs = 1'b0;
      while (!hs && n < 100) begin
        if (stall == 1)      wr_stall = ~wr_stall;
        else if (stall == 2) wr_stall = 1'($urandom_range(0, 1));
        else                 wr_stall = 1'b0;
        #1;
        hs = intf.s_axi_wready;
        @(posedge clk);
        @(negedge clk);
        n++;
      end
      if (!hs) begin
        chk("w_ready_timeout", 32'(hs), 32'd1);
        intf.s_axi_wvalid = 1'b0;
        wr_stall = 1'b0;
        return;
      end
      m_beat++;
      if (ok) begin
        word = int'(addr >> 2) + i;
        for (int b = 0; b < 4; b++) if (ws[i][b]) mem_m[word][b*8 +: 8] = wd[i][b*8 +: 8];
        mem_v[word] = 1'b1;
      end
      if (i == abort_at) begin
        intf.s_axi_wvalid = 1'b0;
        wr_stall = 1'b0;
        rst = 1'b1;
        m_burst = 0;
        m_beat  = 0;
        m_err   = 0;
        #1;
        chk("abort_bvalid", 32'(intf.s_axi_bvalid), 32'd0);
        chk("abort_awready", 32'(intf.s_axi_awready), 32'd0);
        chk_counters("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          #1;
          chk("post_abort_bvalid", 32'(intf.s_axi_bvalid), 32'd0);
        end
        return;
      end
    end
    intf.s_axi_wvalid = 1'b0;
    intf.s_axi_wlast  = 1'b0;
    wr_stall = 1'b0;
    #1;
    chk("b_latency", 32'(intf.s_axi_bvalid), 32'd1);

    intf.s_axi_bready = (bdelay == 0);
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      n++;
      if (!intf.s_axi_bvalid) break;
      if (n >= bdelay) intf.s_axi_bready = 1'b1;
      if (n > 200) begin
        chk("b_timeout", 32'(intf.s_axi_bvalid), 32'd0);
        intf.s_axi_bready = 1'b0;
        return;
      end
    end
    intf.s_axi_bready = 1'b0;
    m_burst++;
    if (cls != 2'b00) m_err++;
    chk_counters("post_b");
    chk("awready_after_b", 32'(intf.s_axi_awready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, wlb, word;
    logic [31:0] addr;
    logic [2:0] size;
    logic [1:0] burst;

    rst = 1'b1;
    wr_stall = 1'b0;
    rd_idx = '0;
    intf.s_axi_awaddr = '0; intf.s_axi_awprot = '0; intf.s_axi_awlen = '0;
    intf.s_axi_awsize = '0; intf.s_axi_awburst = '0; intf.s_axi_awvalid = 1'b0;
    intf.s_axi_wdata = '0; intf.s_axi_wstrb = '0; intf.s_axi_wlast = 1'b0;
    intf.s_axi_wvalid = 1'b0; intf.s_axi_bready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(intf.s_axi_awready), 32'd0);
    chk("rst_bvalid",  32'(intf.s_axi_bvalid),  32'd0);
    chk("rst_bresp",   32'(intf.s_axi_bresp),   32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk_counters("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("awready_after_rst", 32'(intf.s_axi_awready), 32'd1);

    // Plain 16-beat burst, data 0..15.
    for (int i = 0; i < 16; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
    do_burst(32'h0, 15, 3'd2, 2'b01, -1, 0, 0, -1);
    rd_idx = 10'd5;
    @(negedge clk); @(negedge clk); #1;
    chk("rd_idx5", rd_data, 32'd5);

    // Stalled W channel, B held off for 3 cycles.
    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_burst(32'h0, 15, 3'd2, 2'b01, -1, 1, 3, -1);
    for (int i = 0; i < 16; i++) rd_chk(i);

    // Preload the top 4 words, then an out-of-range burst over them.
    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_burst(32'hFF0, 3, 3'd2, 2'b01, -1, 0, 0, -1);
    for (int i = 0; i < 16; i++) wd[i] = $urandom;
    do_burst(32'hFF0, 15, 3'd2, 2'b01, -1, 0, 1, -1);
    for (int i = 1020; i < 1024; i++) rd_chk(i);

    // Early wlast on beat 7: data still written, SLVERR.
    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_burst(32'h100, 15, 3'd2, 2'b01, 7, 0, 0, -1);
    rd_chk(64); rd_chk(71); rd_chk(79);

    // Byte-strobe merge.
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    do_burst(32'h200, 0, 3'd2, 2'b01, -1, 0, 0, -1);
    wd[0] = 32'h0; ws[0] = 4'b0101;
    do_burst(32'h200, 0, 3'd2, 2'b01, -1, 0, 0, -1);
    rd_idx = 10'd128;
    @(negedge clk); @(negedge clk); #1;
    chk("strb_merge", rd_data, 32'hFF00_FF00);

    // Reset after beat 4, then a fresh burst.
    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_burst(32'h400, 15, 3'd2, 2'b01, -1, 0, 0, 4);
    for (int i = 256; i < 261; i++) rd_chk(i);
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_burst(32'h800, 7, 3'd2, 2'b01, -1, 0, 0, -1);
    rd_chk(512); rd_chk(519);

    // Randomized bursts.
    for (int t = 0; t < 25; t++) begin
      addr  = 32'($urandom_range(0, 4400));
      len   = $urandom_range(0, 31);
      size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'd2;
      burst = ($urandom_range(0, 9) == 0) ? 2'd2 : 2'd1;
      wlb   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
      for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
      do_burst(addr, len, size, burst, wlb, $urandom_range(0, 2), $urandom_range(0, 3), -1);
      word = int'(addr >> 2) + $urandom_range(0, len);
      if (word < DEPTH) rd_chk(word);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
